// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and occupancy-derived flags.
// Pointers carry one extra bit so they wrap modulo twice the depth.
module sync_fifo #(
  parameter int DATA_WIDTH = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_CNT = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] ONE       = PW'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_pointer;
  logic [PW-1:0]         wr_pointer;
  logic [PW-1:0]         status_cnt;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full  = (status_cnt == DEPTH_CNT);
  assign empty = (status_cnt == '0);
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  // Storage is not cleared on reset; pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (!arst && wr_ok) begin
      mem[wr_pointer[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      rd_pointer <= '0;
      wr_pointer <= '0;
      status_cnt <= '0;
      data_out   <= '0;
    end else begin
      if (wr_ok) begin
        wr_pointer <= wr_pointer + ONE;
      end
      if (rd_ok) begin
        rd_pointer <= rd_pointer + ONE;
        data_out   <= mem[rd_pointer[AW-1:0]];
      end
      case ({wr_ok, rd_ok})
        2'b10:   status_cnt <= status_cnt + ONE;
        2'b01:   status_cnt <= status_cnt - ONE;
        default: status_cnt <= status_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: reset, fill/overflow, drain/underflow,
// wrap with simultaneous access, full-with-both, and mid-operation reset.
module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        arst;
  logic        wr_en;
  logic        rd_en;
  logic [14:0] data_in;
  logic [14:0] data_out;
  logic        full;
  logic        empty;

  int total = 0;
  int bad   = 0;

  logic [14:0] fill_vals [4];

  sync_fifo #(.DATA_WIDTH(15), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .arst     (arst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    fill_vals[0] = 15'h1111;
    fill_vals[1] = 15'h2222;
    fill_vals[2] = 15'h3333;
    fill_vals[3] = 15'h4444;

    arst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    step();
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_cnt", 32'(dut.status_cnt), 32'h0);
    chk("rst_rd_ptr", 32'(dut.rd_pointer), 32'h0);
    chk("rst_wr_ptr", 32'(dut.wr_pointer), 32'h0);
    arst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; data_in = fill_vals[i];
      step();
      chk("fill_cnt", 32'(dut.status_cnt), 32'(i + 1));
      chk("fill_empty", 32'(empty), 32'h0);
      chk("fill_full", 32'(full), (i == 3) ? 32'h1 : 32'h0);
    end

    data_in = 15'h5555;
    step();
    chk("ovf_cnt", 32'(dut.status_cnt), 32'h4);
    chk("ovf_wr_ptr", 32'(dut.wr_pointer), 32'h4);
    chk("ovf_full", 32'(full), 32'h1);

    wr_en = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_data", 32'(data_out), 32'(fill_vals[i]));
      chk("drain_cnt", 32'(dut.status_cnt), 32'(3 - i));
      chk("drain_empty", 32'(empty), (i == 3) ? 32'h1 : 32'h0);
    end
    step();
    chk("udf_data_hold", 32'(data_out), 32'h4444);
    chk("udf_rd_ptr", 32'(dut.rd_pointer), 32'h4);
    chk("udf_cnt", 32'(dut.status_cnt), 32'h0);

    rd_en = 1'b0; wr_en = 1'b1; data_in = 15'h0A0A;
    step();
    chk("wrap_pre_cnt", 32'(dut.status_cnt), 32'h1);
    chk("wrap_pre_wr_ptr", 32'(dut.wr_pointer), 32'h5);

    rd_en = 1'b1; data_in = 15'h0B0B;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("wrap_cnt", 32'(dut.status_cnt), 32'h1);
      chk("wrap_data", 32'(data_out), (i == 0) ? 32'h0A0A : 32'h0B0B);
    end
    chk("wrap_rd_ptr", 32'(dut.rd_pointer), 32'h2);
    chk("wrap_wr_ptr", 32'(dut.wr_pointer), 32'h3);

    wr_en = 1'b0;
    step();
    chk("wrap_last_data", 32'(data_out), 32'h0B0B);
    chk("wrap_last_empty", 32'(empty), 32'h1);

    // Refill to full, then request both: only the read may take effect.
    rd_en = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 15'(16'h0C01 + 16'(i));
      step();
    end
    chk("both_pre_full", 32'(full), 32'h1);
    rd_en = 1'b1; data_in = 15'h7777;
    step();
    chk("both_full_cnt", 32'(dut.status_cnt), 32'h3);
    chk("both_full_data", 32'(data_out), 32'h0C01);
    wr_en = 1'b0;
    step();
    chk("both_full_next", 32'(data_out), 32'h0C02);
    chk("mid_pre_cnt", 32'(dut.status_cnt), 32'h2);

    rd_en = 1'b0; wr_en = 1'b1; data_in = 15'h0D0D;
    step();
    chk("mid_three_cnt", 32'(dut.status_cnt), 32'h3);

    arst = 1'b1; data_in = 15'h0E0E;
    step();
    chk("mid_rst_cnt", 32'(dut.status_cnt), 32'h0);
    chk("mid_rst_empty", 32'(empty), 32'h1);
    chk("mid_rst_full", 32'(full), 32'h0);
    chk("mid_rst_data", 32'(data_out), 32'h0);
    chk("mid_rst_wr_ptr", 32'(dut.wr_pointer), 32'h0);
    chk("mid_rst_rd_ptr", 32'(dut.rd_pointer), 32'h0);

    arst = 1'b0; wr_en = 1'b0; rd_en = 1'b1;
    step();
    chk("post_rst_rd_data", 32'(data_out), 32'h0);
    chk("post_rst_rd_ptr", 32'(dut.rd_pointer), 32'h0);
    chk("post_rst_cnt", 32'(dut.status_cnt), 32'h0);
    rd_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 15, width in bits of each stored word.
REQ-002 Parameter FIFO_DEPTH, default 4, number of storage entries; SHALL be a power of two >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 arst  input  1  reset, synchronous and active-high; sampled on rising clk edge only.
REQ-005 wr_en  input  1  write request.
REQ-006 rd_en  input  1  read request.
REQ-007 data_in  input  DATA_WIDTH  write data.
REQ-008 data_out  output  DATA_WIDTH  registered read data.
REQ-009 full  output  1  high when FIFO holds FIFO_DEPTH entries.
REQ-010 empty  output  1  high when FIFO holds 0 entries.
REQ-011 Internal registers named rd_pointer, wr_pointer, status_cnt SHALL exist at module top level, each $clog2(FIFO_DEPTH)+1 bits wide, for hierarchical probing by benches.

Function
REQ-012 Storage SHALL be a FIFO_DEPTH x DATA_WIDTH register array, addressed by the low $clog2(FIFO_DEPTH) bits of each pointer.
REQ-013 A write is accepted on a rising edge when wr_en=1 and full=0: data_in stored at wr_pointer, wr_pointer increments by 1.
REQ-014 A read is accepted on a rising edge when rd_en=1 and empty=0: entry at rd_pointer loaded into data_out, rd_pointer increments by 1; read latency one clock from the rd_en edge.
REQ-015 Pointers SHALL wrap naturally modulo 2*FIFO_DEPTH (full-width increment); array addressing wraps modulo FIFO_DEPTH.
REQ-016 wr_en while full SHALL be ignored: no storage change, no pointer change, no error flag.
REQ-017 rd_en while empty SHALL be ignored: data_out holds its previous value, no pointer change.
REQ-018 data_out SHALL hold its last value whenever no read is accepted.
REQ-019 status_cnt SHALL equal number of stored entries (0..FIFO_DEPTH): +1 on accepted write only, -1 on accepted read only, unchanged when both or neither accepted.
REQ-020 Simultaneous wr_en and rd_en: each is qualified independently by the full/empty values before the edge; when not full and not empty, both occur and status_cnt is unchanged; when full, only the read occurs; when empty, only the write occurs.
REQ-021 full SHALL be combinational: status_cnt == FIFO_DEPTH.
REQ-022 empty SHALL be combinational: status_cnt == 0.
REQ-023 Stored data SHALL be returned in exact write order with no corruption across pointer wrap.

Reset
REQ-024 When arst=1 at a rising edge: rd_pointer, wr_pointer, status_cnt, data_out SHALL become 0; empty=1, full=0 after that edge.
REQ-025 Reset SHALL take priority over concurrent wr_en/rd_en; in-flight contents are discarded (array contents need not be cleared).
REQ-026 Reset asserted mid-operation (partially full or full) SHALL produce the same state as REQ-024 on the next edge.

Verification
REQ-027 Reset: arst=1 for one edge -> data_out=0, empty=1, full=0, status_cnt=0, both pointers 0.
REQ-028 Fill: write 0x1111,0x2222,0x3333,0x4444 on consecutive edges -> status_cnt 1,2,3,4; full=1 after 4th edge, empty=0 after 1st.
REQ-029 Overflow: fifth write 0x5555 while full -> status_cnt stays 4, wr_pointer stays 4, later reads never return 0x5555.
REQ-030 Drain: rd_en for 4 edges -> data_out 0x1111,0x2222,0x3333,0x4444 one cycle after each edge; empty=1 after 4th; fifth rd_en holds data_out=0x4444.
REQ-031 Wrap and simultaneous: after drain write 0x0A0A, then wr_en=rd_en=1 with data_in 0x0B0B for 6 edges -> status_cnt stays 1, pointers cross 7->0, data_out sequence begins 0x0A0A,0x0B0B in order.
REQ-032 Reset mid-operation: with 3 entries stored, pulse arst with wr_en=1 -> status_cnt=0, empty=1, data_out=0; next read attempt ignored.
